// File: rtl/bin2rns_serial_pkg.sv
// rtl/bin2rns_serial_pkg.sv - shared RNS types and constants for bin2rns_serial / rns2bin
package bin2rns_serial_pkg;

    localparam int     N_MOD = 7;
    localparam longint M     = 64'd12252240;
    localparam int     RNS_W = 78;

    typedef struct packed {
        logic [15:0] x16;
        logic [8:0]  x9;
        logic [4:0]  x5;
        logic [6:0]  x7;
        logic [10:0] x11;
        logic [12:0] x13;
        logic [16:0] x17;
    } rns0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Residue index reached from index i after one Horner step with bit b.
    function automatic int dbl_idx(input int i, input int b, input int m);
        return (2 * i + b) % m;
    endfunction

    function automatic int neg_idx(input int i, input int m);
        return (m - i) % m;
    endfunction

endpackage

// File: rtl/bin2rns_serial_onehot_mac.sv
// rtl/bin2rns_serial_onehot_mac.sv - one-hot residue register with doubling-plus-bit step
// Optional negation on the final step when BIN2RNS_SIGNED_EN is defined.
module onehot_mac
    import bin2rns_serial_pkg::*;
#(
    parameter int MOD = 16
) (
    input  logic           clk,
    input  logic           i_clr_n,
    input  logic           i_load,
    input  logic           i_step,
    input  logic           i_bit,
`ifdef BIN2RNS_SIGNED_EN
    input  logic           i_neg,
`endif
    output logic [MOD-1:0] o_res
);

    localparam logic [MOD-1:0] ONEHOT_ZERO = MOD'(1);

    // Source bits that land on destination j for a given input bit b.
    function automatic logic [MOD-1:0] src_mask(input int j, input int b);
        logic [MOD-1:0] m;
        m = '0;
        for (int i = 0; i < MOD; i++) begin
            if (dbl_idx(i, b, MOD) == j) m |= (MOD'(1) << i);
        end
        return m;
    endfunction

    logic [MOD-1:0] r_res;
    logic [MOD-1:0] w_step;
    logic [MOD-1:0] w_next;

    for (genvar j = 0; j < MOD; j++) begin : g_perm
        localparam logic [MOD-1:0] S0 = src_mask(j, 0);
        localparam logic [MOD-1:0] S1 = src_mask(j, 1);
        assign w_step[j] = |(r_res & (i_bit ? S1 : S0));
    end

`ifdef BIN2RNS_SIGNED_EN
    logic [MOD-1:0] w_negd;
    for (genvar j = 0; j < MOD; j++) begin : g_neg
        localparam int NJ = neg_idx(j, MOD);
        assign w_negd[j] = w_step[NJ];
    end
    assign w_next = i_neg ? w_negd : w_step;
`else
    assign w_next = w_step;
`endif

    always_ff @(posedge clk) begin
        if (!i_clr_n || i_load) begin
            r_res <= ONEHOT_ZERO;
        end else if (i_step) begin
            r_res <= w_next;
        end
    end

    assign o_res = r_res;

endmodule

// File: rtl/bin2rns_serial.sv
// rtl/bin2rns_serial.sv - serial MSB-first binary-to-RNS converter, one-hot residues
// BIN2RNS_SIGNED_EN: treat in_data as two's complement and emit M-|x| for negatives.
module bin2rns_serial
    import bin2rns_serial_pkg::*;
#(
    parameter int W = 23
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output rns0          out_rns,
    output logic         busy
);

    localparam int CW = $clog2(W);

    state_t         r_state;
    state_t         w_state_next;
    logic [W-1:0]   r_shreg;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   w_mag;
    logic           w_accept;
    logic           w_step;
    logic           w_bit;

    assign w_accept = in_valid && (r_state == ST_IDLE);
    assign w_step   = (r_state == ST_RUN);
    assign w_bit    = r_shreg[W-1];

`ifdef BIN2RNS_SIGNED_EN
    logic r_neg;
    logic w_neg;

    assign w_mag = in_data[W-1] ? (-in_data) : in_data;
    // Negate only on the RUN-to-DONE update so no extra cycle is spent.
    assign w_neg = r_neg && w_step && (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_neg <= 1'b0;
        end else if (w_accept) begin
            r_neg <= in_data[W-1];
        end
    end
`else
    assign w_mag = in_data;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)      w_state_next = ST_RUN;
            ST_RUN:  if (r_cnt == '0)   w_state_next = ST_DONE;
            ST_DONE: if (out_ready)     w_state_next = ST_IDLE;
            default:                    w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_shreg <= w_mag;
                r_cnt   <= CW'(W - 1);
            end else if (w_step) begin
                r_shreg <= r_shreg << 1;
                r_cnt   <= r_cnt - CW'(1);
            end
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state == ST_RUN);

`ifdef BIN2RNS_SIGNED_EN
    `define B2R_NEG .i_neg(w_neg),
`else
    `define B2R_NEG
`endif

    onehot_mac #(.MOD(16)) u_mac16 (
        .clk(clk), .i_clr_n(rst), .i_load(w_accept), .i_step(w_step), .i_bit(w_bit),
        `B2R_NEG .o_res(out_rns.x16)
    );
    onehot_mac #(.MOD(9)) u_mac9 (
        .clk(clk), .i_clr_n(rst), .i_load(w_accept), .i_step(w_step), .i_bit(w_bit),
        `B2R_NEG .o_res(out_rns.x9)
    );
    onehot_mac #(.MOD(5)) u_mac5 (
        .clk(clk), .i_clr_n(rst), .i_load(w_accept), .i_step(w_step), .i_bit(w_bit),
        `B2R_NEG .o_res(out_rns.x5)
    );
    onehot_mac #(.MOD(7)) u_mac7 (
        .clk(clk), .i_clr_n(rst), .i_load(w_accept), .i_step(w_step), .i_bit(w_bit),
        `B2R_NEG .o_res(out_rns.x7)
    );
    onehot_mac #(.MOD(11)) u_mac11 (
        .clk(clk), .i_clr_n(rst), .i_load(w_accept), .i_step(w_step), .i_bit(w_bit),
        `B2R_NEG .o_res(out_rns.x11)
    );
    onehot_mac #(.MOD(13)) u_mac13 (
        .clk(clk), .i_clr_n(rst), .i_load(w_accept), .i_step(w_step), .i_bit(w_bit),
        `B2R_NEG .o_res(out_rns.x13)
    );
    onehot_mac #(.MOD(17)) u_mac17 (
        .clk(clk), .i_clr_n(rst), .i_load(w_accept), .i_step(w_step), .i_bit(w_bit),
        `B2R_NEG .o_res(out_rns.x17)
    );

    `undef B2R_NEG

endmodule

// File: tb/tb_bin2rns_serial.sv
// tb/tb_bin2rns_serial.sv - scoreboard bench for bin2rns_serial (honours BIN2RNS_SIGNED_EN)
module tb_bin2rns_serial;
    import bin2rns_serial_pkg::*;

    localparam int W = 23;

    logic         clk       = 1'b0;
    logic         rst       = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data   = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    rns0          out_rns;
    logic         busy;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [77:0]  sb_q[$];

    always #5 clk = ~clk;

    bin2rns_serial #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rns   (out_rns),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [77:0] got, input logic [77:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int mod_idx(input longint v, input int m);
        return int'(v % longint'(m));
    endfunction

    // Expected residues computed arithmetically from the input value.
    function automatic logic [77:0] model(input logic [W-1:0] d);
        longint v;
        rns0    r;
        v = longint'(d);
`ifdef BIN2RNS_SIGNED_EN
        if (d[W-1]) v = M - ((longint'(1) << W) - v);
`endif
        r.x16 = 16'(1) << mod_idx(v, 16);
        r.x9  = 9'(1)  << mod_idx(v, 9);
        r.x5  = 5'(1)  << mod_idx(v, 5);
        r.x7  = 7'(1)  << mod_idx(v, 7);
        r.x11 = 11'(1) << mod_idx(v, 11);
        r.x13 = 13'(1) << mod_idx(v, 13);
        r.x17 = 17'(1) << mod_idx(v, 17);
        return r;
    endfunction

    task automatic send(input logic [W-1:0] d);
        int n;
        n = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("accept_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb_q.push_back(model(d));
        check("busy_run", busy, 1'b1);
        check("in_ready_run", in_ready, 1'b0);
    endtask

    // Must follow send() directly: n starts at 1, the accept edge already passed.
    task automatic collect(input bit chk_lat, input int hold);
        int          n;
        logic [77:0] exp;
        n = 1;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (chk_lat) check("latency", 78'(n), 78'(W + 1));
        if (sb_q.size() == 0) begin
            check("sb_underflow", 1'b1, 1'b0);
            exp = '0;
        end else begin
            exp = sb_q.pop_front();
        end
        for (int k = 0; k < hold; k++) begin
            check("bp_valid", out_valid, 1'b1);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_rns", out_rns, exp);
            @(posedge clk); #1;
        end
        check("result", out_rns, exp);
        check("result_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("valid_drop", out_valid, 1'b0);
        check("in_ready_back", in_ready, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        stale;
        logic [77:0] zero_v;
        zero_v = model('0);

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rns", out_rns, zero_v);
        rst = 1'b1;
        @(posedge clk); #1;

        send(23'd0);        collect(1'b1, 0);
        send(23'd100);      collect(1'b1, 0);
        send(23'h7FFFFF);   collect(1'b1, 0);
        send(23'h400000);   collect(1'b0, 0);
        send(23'd12345);    collect(1'b0, 10);

        send(23'd77);
        repeat (9) @(posedge clk);
        #1;
        check("busy_mid", busy, 1'b1);
        rst = 1'b0;
        @(posedge clk); #1;
        void'(sb_q.pop_back());
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_rns", out_rns, zero_v);
        rst = 1'b1;
        stale = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid) stale = 1'b1;
        end
        check("no_stale", stale, 1'b0);
        send(23'd5);        collect(1'b1, 0);

        for (int i = 0; i < 1000; i++) begin
            send(W'($urandom_range(0, (1 << W) - 1)));
            collect(1'b0, 0);
        end

        check("sb_empty", 78'(sb_q.size()), 78'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
